// File: rtl/led_pattern_gen_pkg.sv
// Shared constants for the LED pattern generator: mode encodings, switch field
// positions, bounce heading type and a width helper.
package led_pattern_pkg;

    localparam logic [1:0] MODE_BLINK  = 2'b00;
    localparam logic [1:0] MODE_CHASE  = 2'b01;
    localparam logic [1:0] MODE_BOUNCE = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    localparam int SW_MODE_LO = 0;
    localparam int SW_MODE_HI = 1;
    localparam int SW_SPD_LO  = 2;
    localparam int SW_SPD_HI  = 4;
    localparam int SW_RUN     = 5;
    localparam int SW_DIR     = 6;
    localparam int SW_INV     = 7;

    typedef enum logic {
        HEAD_UP = 1'b0,
        HEAD_DN = 1'b1
    } heading_t;

    // Bits needed to hold values 0..v-1; never less than 1.
    function automatic int clog2(input logic [63:0] v);
        int r;
        r = 0;
        while ((64'd1 << r) < v) begin
            r = r + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/led_pattern_gen_tick_divider.sv
// Prescaler: free-running counter 0..DIV_VALUE that emits one base tick per wrap
// and holds its count while en is low.
module tick_divider
    import led_pattern_pkg::*;
#(
    parameter int DIV_VALUE = 49999999
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);

    localparam int CW = clog2(64'(DIV_VALUE) + 64'd1);
    localparam logic [CW-1:0] TERM = CW'(DIV_VALUE);

    logic [CW-1:0] div_cnt;

    assign tick = en && (div_cnt == TERM);

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (en) begin
            if (div_cnt == TERM) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// LED pattern generator: switch synchroniser, speed stretcher, four-mode pattern
// FSM and registered LED/step outputs.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter int N_LEDS    = 8,
    parameter int DIV_VALUE = 49999999,
    parameter int SYNC_STG  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        sw,
    output logic [N_LEDS-1:0] led,
    output logic              step
);

    logic [7:0]        sw_p [SYNC_STG];
    logic [7:0]        s_sw;
    logic [1:0]        mode_p0, mode_p1;
    logic [2:0]        speed_p0, speed_p1;
    logic              mode_chg, spd_chg;
    logic              run, dir, inv;
    logic              base_tick, step_pulse;
    logic [6:0]        step_cnt, step_mask;
    logic [N_LEDS-1:0] pattern, pattern_nxt;
    heading_t          heading, heading_nxt, heading_eff;

    // Stage: switch synchroniser
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STG; i++) begin
                sw_p[i] <= '0;
            end
        end else begin
            sw_p[0] <= sw;
            for (int i = 1; i < SYNC_STG; i++) begin
                sw_p[i] <= sw_p[i-1];
            end
        end
    end

    assign s_sw     = sw_p[SYNC_STG-1];
    assign mode_p0  = s_sw[SW_MODE_HI:SW_MODE_LO];
    assign speed_p0 = s_sw[SW_SPD_HI:SW_SPD_LO];
    assign run      = s_sw[SW_RUN];
    assign dir      = s_sw[SW_DIR];
    assign inv      = s_sw[SW_INV];
    assign mode_chg = (mode_p0 != mode_p1);
    assign spd_chg  = (speed_p0 != speed_p1);

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_p1  <= '0;
            speed_p1 <= '0;
        end else begin
            mode_p1  <= mode_p0;
            speed_p1 <= speed_p0;
        end
    end

    // Stage: prescaler and speed stretcher
    tick_divider #(
        .DIV_VALUE (DIV_VALUE)
    ) u_div (
        .clk  (clk),
        .rst  (rst),
        .en   (run),
        .tick (base_tick)
    );

    assign step_mask  = 7'((8'd1 << speed_p0) - 8'd1);
    assign step_pulse = base_tick && (step_cnt == step_mask);

    always_ff @(posedge clk) begin
        if (rst) begin
            step_cnt <= '0;
        end else if (spd_chg) begin
            step_cnt <= '0;
        end else if (base_tick) begin
            step_cnt <= step_pulse ? 7'd0 : step_cnt + 7'd1;
        end
    end

    // Stage: pattern FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            pattern <= '0;
            heading <= HEAD_UP;
        end else begin
            pattern <= pattern_nxt;
            heading <= heading_nxt;
        end
    end

    always_comb begin
        pattern_nxt = pattern;
        heading_nxt = heading;
        heading_eff = heading;
        if (mode_chg) begin
            // Entering a mode restarts it from its init value; this beats a coincident step.
            heading_nxt = HEAD_UP;
            if (mode_p0 == MODE_CHASE || mode_p0 == MODE_BOUNCE) begin
                pattern_nxt = N_LEDS'(1);
            end else begin
                pattern_nxt = '0;
            end
        end else if (step_pulse) begin
            case (mode_p0)
                MODE_BLINK: pattern_nxt = ~pattern;
                MODE_CHASE: begin
                    if (dir) begin
                        pattern_nxt = (pattern >> 1) | (pattern << (N_LEDS - 1));
                    end else begin
                        pattern_nxt = (pattern << 1) | (pattern >> (N_LEDS - 1));
                    end
                end
                MODE_BOUNCE: begin
                    if (N_LEDS > 1) begin
                        if (pattern[N_LEDS-1]) begin
                            heading_eff = HEAD_DN;
                        end else if (pattern[0]) begin
                            heading_eff = HEAD_UP;
                        end
                        pattern_nxt = (heading_eff == HEAD_UP) ? (pattern << 1) : (pattern >> 1);
                        heading_nxt = heading_eff;
                    end
                end
                default: pattern_nxt = dir ? (pattern - N_LEDS'(1)) : (pattern + N_LEDS'(1));
            endcase
        end
    end

    // Stage: output register; invert stays live while frozen
    always_ff @(posedge clk) begin
        if (rst) begin
            led  <= '0;
            step <= 1'b0;
        end else begin
            led  <= pattern ^ {N_LEDS{inv}};
            step <= step_pulse;
        end
    end

endmodule
